// File: rtl/mcse_top.sv
// Secure-boot sequencer: host reset handshake, lifecycle authentication, bus wakeup,
// IP ID collection over GPIO, and key-gated lifecycle transitions.
// state      | meaning
// IDLE       | waiting for init_config
// RST_REQ    | host reset requested, waiting for ACK
// AUTH       | waiting for the authentication key of the current lifecycle
// BUS_WAKE   | bus wakeup requested, waiting for ACK
// IPID_TRIG  | trigger asserted, receiving a header/payload/trailer frame
// IPID_WAIT  | trigger dropped, waiting for the host to drop IPID valid
// RELEASE    | operation release requested, waiting for ACK
// OPERATE    | normal operation, accepting lifecycle transition requests
// LOCKED     | end of life, terminal until reset
module mcse_top #(
  parameter int gpio_N     = 32,
  parameter int ipid_N     = 16,
  parameter int ipid_width = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_config,
  input  logic [gpio_N-1:0] gpio_in,
  input  logic [255:0]      lc_transition_id,
  input  logic              lc_transition_request_in,
  input  logic [255:0]      lc_authentication_id,
  input  logic              lc_authentication_valid,
  output logic [gpio_N-1:0] gpio_out
);

  typedef enum logic [3:0] {
    S_IDLE, S_RST_REQ, S_AUTH, S_BUS_WAKE, S_IPID_TRIG,
    S_IPID_WAIT, S_RELEASE, S_OPERATE, S_LOCKED
  } state_t;

  localparam logic [2:0]  LC_MANUF = 3'd0;
  localparam logic [2:0]  LC_EOL   = 3'd4;
  localparam logic [15:0] IPID_HDR = 16'h7A7A;
  localparam logic [15:0] IPID_TRL = 16'hB9B9;
  localparam logic [4:0]  WCNT_TRL = 5'd17;

  function automatic logic [255:0] auth_key(input logic [2:0] lc);
    case (lc)
      3'd1:    auth_key = 256'h431909d9da263164ab4d39614e0c50a32774a49b3390a53ffa63e8d74b8e7c0b;
      3'd2:    auth_key = 256'h8e30701845bea3e44d0aed1ba6d4893a0de91fea6f42571d3714a3c6daa39978;
      3'd3:    auth_key = 256'hd995f5ddfb1625e3a33b0ee123b6672f35df88d6652eaec51d26f3a50b030ad8;
      3'd4:    auth_key = 256'hdf0f326b1bf6611d944491d7a0618af56ac57e391ba38425f9f33cafdd7439a9;
      default: auth_key = '0;
    endcase
  endfunction

  function automatic logic [255:0] trans_key(input logic [2:0] lc);
    case (lc)
      3'd0:    trans_key = 256'h33a344a35afd82155e5a6ef2d092085d704dc70561dde45d27962d79ea56a24a;
      3'd1:    trans_key = 256'h988b6a57b75f5696f01b8207b1c99bc888b4a2421a0ab4b29bd302f5b8a93348;
      3'd2:    trans_key = 256'h4893565d146d9fa19dc850e0c409b2a62ec5cb53eea4d4719c93a882f988284e;
      3'd3:    trans_key = 256'hcabc36e4f52fcd1a8b62d82d975e4c8595da7f6df52e2143174c3dc8b3870e03;
      default: trans_key = '0;
    endcase
  endfunction

  state_t                state_q, state_d;
  logic [2:0]            lc_q, lc_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
  logic [3:0]            addr_q, addr_d;
  logic [4:0]            wcnt_q, wcnt_d;
  logic                  adv_q, adv_d;
  logic                  req_q, req_d;
  logic [ipid_width-1:0] frame_q, frame_d;
  logic [ipid_width-1:0] ipid_q [ipid_N];
  logic [ipid_width-1:0] ipid_d [ipid_N];

  logic        ipid_vld;
  logic [15:0] ipid_word;
  logic        req_edge;
  logic        unused_gpio_in;

  assign ipid_vld       = gpio_in[13];
  assign ipid_word      = gpio_in[31:16];
  assign req_edge       = lc_transition_request_in & ~req_q;
  assign unused_gpio_in = ^{gpio_in[15:14], gpio_in[12:8], gpio_in[6], gpio_in[4:2], gpio_in[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lc_q    <= LC_MANUF;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      wcnt_q  <= '0;
      adv_q   <= 1'b0;
      req_q   <= 1'b0;
      frame_q <= '0;
      for (int i = 0; i < ipid_N; i++) ipid_q[i] <= '0;
    end else begin
      lc_q    <= lc_d;
      err_q   <= err_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      adv_q   <= adv_d;
      req_q   <= req_d;
      frame_q <= frame_d;
      for (int i = 0; i < ipid_N; i++) ipid_q[i] <= ipid_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    lc_d    = lc_q;
    err_d   = err_q;
    done_d  = done_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    adv_d   = adv_q;
    req_d   = lc_transition_request_in;
    frame_d = frame_q;
    ipid_d  = ipid_q;
    case (state_q)
      S_IDLE: if (init_config) state_d = S_RST_REQ;
      S_RST_REQ: begin
        if (gpio_in[1]) begin
          err_d   = 1'b0;
          done_d  = 1'b0;
          state_d = (lc_q == LC_MANUF) ? S_BUS_WAKE : S_AUTH;
        end
      end
      S_AUTH: begin
        if (lc_authentication_valid) begin
          if (lc_authentication_id == auth_key(lc_q))
            state_d = (lc_q == LC_EOL) ? S_LOCKED : S_BUS_WAKE;
          else
            err_d = 1'b1;
        end
      end
      S_BUS_WAKE: begin
        if (gpio_in[7]) begin
          addr_d  = '0;
          wcnt_d  = '0;
          adv_d   = 1'b0;
          state_d = S_IPID_TRIG;
        end
      end
      S_IPID_TRIG: begin
        // The frame is committed to the store only once the trailer checks out.
        if (ipid_vld) begin
          if (wcnt_q == 5'd0) begin
            if (ipid_word == IPID_HDR) begin
              wcnt_d = 5'd1;
            end else begin
              err_d   = 1'b1;
              adv_d   = 1'b0;
              state_d = S_IPID_WAIT;
            end
          end else if (wcnt_q == WCNT_TRL) begin
            wcnt_d  = '0;
            state_d = S_IPID_WAIT;
            if (ipid_word == IPID_TRL) begin
              adv_d          = 1'b1;
              ipid_d[addr_q] = frame_q;
            end else begin
              err_d = 1'b1;
              adv_d = 1'b0;
            end
          end else begin
            frame_d = {frame_q[ipid_width-17:0], ipid_word};
            wcnt_d  = wcnt_q + 5'd1;
          end
        end else if (wcnt_q != 5'd0) begin
          err_d   = 1'b1;
          adv_d   = 1'b0;
          wcnt_d  = '0;
          state_d = S_IPID_WAIT;
        end
      end
      S_IPID_WAIT: begin
        if (!ipid_vld) begin
          if (adv_q) begin
            adv_d = 1'b0;
            if (addr_q == 4'(ipid_N - 1)) begin
              done_d  = 1'b1;
              state_d = S_RELEASE;
            end else begin
              addr_d  = addr_q + 4'd1;
              state_d = S_IPID_TRIG;
            end
          end else begin
            state_d = S_IPID_TRIG;
          end
        end
      end
      S_RELEASE: if (gpio_in[5]) state_d = S_OPERATE;
      S_OPERATE: begin
        if (req_edge) begin
          if (lc_q != LC_EOL && lc_transition_id == trans_key(lc_q)) begin
            lc_d    = lc_q + 3'd1;
            state_d = S_RST_REQ;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOCKED: state_d = S_LOCKED;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gpio_out        = '0;
    gpio_out[18:16] = lc_q;
    if (state_q != S_LOCKED) begin
      gpio_out[14] = err_q;
      gpio_out[15] = done_q;
      case (state_q)
        S_RST_REQ:  gpio_out[0] = 1'b1;
        S_BUS_WAKE: gpio_out[6] = 1'b1;
        S_IPID_TRIG: begin
          gpio_out[12]   = 1'b1;
          gpio_out[11:8] = addr_q;
        end
        S_IPID_WAIT: gpio_out[11:8] = addr_q;
        S_RELEASE, S_OPERATE: gpio_out[4] = 1'b1;
        default: gpio_out[0] = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mcse_top.sv
// Randomized bench for mcse_top: drives boot, IP ID frames and lifecycle walks,
// comparing gpio_out and the IP ID store against a protocol-level model.
module tb_mcse_top;

  logic         clk = 1'b0;
  logic         rst;
  logic         init_config;
  logic [31:0]  gpio_in;
  logic [255:0] lc_transition_id;
  logic         lc_transition_request_in;
  logic [255:0] lc_authentication_id;
  logic         lc_authentication_valid;
  logic [31:0]  gpio_out;

  mcse_top dut (
    .clk                      (clk),
    .rst                      (rst),
    .init_config              (init_config),
    .gpio_in                  (gpio_in),
    .lc_transition_id         (lc_transition_id),
    .lc_transition_request_in (lc_transition_request_in),
    .lc_authentication_id     (lc_authentication_id),
    .lc_authentication_valid  (lc_authentication_valid),
    .gpio_out                 (gpio_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [255:0] auth_key  [5];
  logic [255:0] trans_key [4];
  logic [255:0] m_ipid    [16];
  int           m_lc;
  bit           m_err;
  bit           m_done;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Control bits plus the model's lifecycle/error/done flags.
  function automatic logic [31:0] exp_out(input logic [31:0] ctl);
    logic [31:0] v;
    v = ctl;
    v[14] = m_err;
    v[15] = m_done;
    v[18:16] = 3'(m_lc);
    return v;
  endfunction

  task automatic wait_bit(input int idx, input logic v, input string tag);
    int n = 0;
    while (gpio_out[idx] !== v && n < 50) begin
      tick();
      n++;
    end
    chk(tag, gpio_out[idx], v);
  endtask

  task automatic drive_word(input logic [15:0] w);
    gpio_in[31:16] = w;
    gpio_in[13]    = 1'b1;
    tick();
  endtask

  task automatic good_frame(input int a);
    logic [255:0] v = '0;
    logic [15:0]  w;
    repeat ($urandom_range(2)) tick();
    drive_word(16'h7A7A);
    for (int i = 0; i < 16; i++) begin
      w = 16'($urandom);
      v = {v[239:0], w};
      drive_word(w);
    end
    drive_word(16'hB9B9);
    gpio_in[13] = 1'b0;
    m_ipid[a] = v;
    chk("frame_end", gpio_out, exp_out(32'(a) << 8));
    tick();
    if (a < 15) chk("trig_next", gpio_out, exp_out(32'h1000 | (32'(a + 1) << 8)));
    else begin
      m_done = 1'b1;
      chk("release", gpio_out, exp_out(32'h10));
    end
  endtask

  // kind 0: bad header, 1: bad trailer, 2: valid dropped mid-frame
  task automatic bad_frame(input int a, input int kind, input logic [15:0] hdr);
    logic [15:0] w;
    repeat ($urandom_range(2)) tick();
    if (kind == 0) begin
      drive_word(hdr);
    end else begin
      drive_word(16'h7A7A);
      if (kind == 1) begin
        for (int i = 0; i < 16; i++) drive_word(16'($urandom));
        do w = 16'($urandom); while (w == 16'hB9B9);
        drive_word(w);
      end else begin
        repeat ($urandom_range(0, 16)) drive_word(16'($urandom));
        gpio_in[13] = 1'b0;
        tick();
      end
    end
    gpio_in[13] = 1'b0;
    m_err = 1'b1;
    chk($sformatf("bad_frame_k%0d", kind), gpio_out, exp_out(32'(a) << 8));
    tick();
    chk("retry_same_addr", gpio_out, exp_out(32'h1000 | (32'(a) << 8)));
  endtask

  task automatic do_boot();
    logic [15:0] h;
    int nf;
    wait_bit(0, 1'b1, "rst_req_wait");
    chk("rst_req", gpio_out, exp_out(32'h1));
    gpio_in[1] = 1'b1;
    tick();
    gpio_in[1] = 1'b0;
    m_err  = 1'b0;
    m_done = 1'b0;
    if (m_lc != 0) begin
      chk("auth_wait", gpio_out, exp_out(32'h0));
      lc_transition_id         = trans_key[(m_lc - 1) % 4];
      lc_transition_request_in = 1'b1;
      lc_authentication_id     = auth_key[m_lc] ^ (256'h1 << $urandom_range(255));
      lc_authentication_valid  = 1'b1;
      tick();
      lc_transition_request_in = 1'b0;
      m_err = 1'b1;
      chk("auth_bad", gpio_out, exp_out(32'h0));
      lc_authentication_id = auth_key[m_lc];
      tick();
      lc_authentication_valid = 1'b0;
      if (m_lc == 4) begin
        chk("locked", gpio_out, 32'h0004_0000);
        return;
      end
    end
    chk("bus_wake", gpio_out, exp_out(32'h40));
    gpio_in[7] = 1'b1;
    tick();
    gpio_in[7] = 1'b0;
    chk("trig0", gpio_out, exp_out(32'h1000));
    for (int a = 0; a < 16; a++) begin
      nf = (a == 3) ? 1 : (($urandom_range(3) == 0) ? 1 : 0);
      for (int f = 0; f < nf; f++) begin
        if (a == 3) bad_frame(a, 0, 16'h1234);
        else begin
          do h = 16'($urandom); while (h == 16'h7A7A);
          bad_frame(a, $urandom_range(2), h);
        end
      end
      good_frame(a);
    end
    for (int a = 0; a < 16; a++)
      chk($sformatf("ipid%0d", a), dut.ipid_q[a], m_ipid[a]);
    gpio_in[5] = 1'b1;
    tick();
    gpio_in[5] = 1'b0;
    repeat ($urandom_range(1, 3)) tick();
    chk("operate", gpio_out, exp_out(32'h10));
  endtask

  task automatic trans_bad();
    lc_transition_id         = trans_key[m_lc] ^ (256'h1 << $urandom_range(255));
    lc_transition_request_in = 1'b1;
    tick();
    m_err = 1'b1;
    chk("trans_bad", gpio_out, exp_out(32'h10));
    lc_transition_id = trans_key[m_lc];
    tick();
    chk("trans_level_ignored", gpio_out, exp_out(32'h10));
    lc_transition_request_in = 1'b0;
    tick();
  endtask

  task automatic trans_good();
    lc_transition_id         = trans_key[m_lc];
    lc_transition_request_in = 1'b1;
    tick();
    lc_transition_request_in = 1'b0;
    m_lc++;
    chk("trans_ok", gpio_out, exp_out(32'h1));
  endtask

  initial begin
    auth_key[0]  = '0;
    auth_key[1]  = 256'h431909d9da263164ab4d39614e0c50a32774a49b3390a53ffa63e8d74b8e7c0b;
    auth_key[2]  = 256'h8e30701845bea3e44d0aed1ba6d4893a0de91fea6f42571d3714a3c6daa39978;
    auth_key[3]  = 256'hd995f5ddfb1625e3a33b0ee123b6672f35df88d6652eaec51d26f3a50b030ad8;
    auth_key[4]  = 256'hdf0f326b1bf6611d944491d7a0618af56ac57e391ba38425f9f33cafdd7439a9;
    trans_key[0] = 256'h33a344a35afd82155e5a6ef2d092085d704dc70561dde45d27962d79ea56a24a;
    trans_key[1] = 256'h988b6a57b75f5696f01b8207b1c99bc888b4a2421a0ab4b29bd302f5b8a93348;
    trans_key[2] = 256'h4893565d146d9fa19dc850e0c409b2a62ec5cb53eea4d4719c93a882f988284e;
    trans_key[3] = 256'hcabc36e4f52fcd1a8b62d82d975e4c8595da7f6df52e2143174c3dc8b3870e03;
    m_lc   = 0;
    m_err  = 1'b0;
    m_done = 1'b0;

    rst                      = 1'b1;
    init_config              = 1'b1;
    gpio_in                  = '0;
    lc_transition_id         = '0;
    lc_transition_request_in = 1'b0;
    lc_authentication_id     = '0;
    lc_authentication_valid  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", gpio_out, 32'h0);
    rst = 1'b0;

    do_boot();
    for (int i = 0; i < 4; i++) begin
      if (i == 0 || $urandom_range(1) == 1) trans_bad();
      trans_good();
      do_boot();
    end

    repeat (5) begin
      gpio_in                  = $urandom;
      lc_transition_request_in = ~lc_transition_request_in;
      tick();
      chk("locked_hold", gpio_out, 32'h0004_0000);
    end

    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", gpio_out, 32'h0);
    init_config = 1'b0;
    gpio_in     = '0;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("idle_after_rst", gpio_out, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule
